// File: rtl/scsp_pkg.sv
// Shared SCSP definitions used by the MIDI output path.
// Holds the transmitter state type, the default baud divider and a counter width helper.
package scsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } MidiTxState_t;

  // 31.25 kbaud from the 22.5792 MHz CE rate.
  localparam int MIDI_BAUD_DIV  = 722;
  localparam int MIDI_DATA_BITS = 8;

  function automatic int midi_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scsp_midi_fifo.sv
// MOBUF byte FIFO feeding the MIDI transmitter.
// A push into a full FIFO is accepted only when a pop frees a slot on the same clock.
module scsp_midi_fifo
  import scsp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = midi_cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Flags are registered from the next count so they always agree with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
    end
  end

endmodule

// File: rtl/scsp_midi_tx.sv
// SCSP MIDI output: MOBUF FIFO plus an 8N1 serializer timed by CE ticks.
// Frames are sent back to back while bytes are queued; MO_IRQ marks the final stop bit.
module scsp_midi_tx
  import scsp_pkg::*;
#(
  parameter int BAUD_DIV   = MIDI_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       MOBUF_WR,
  input  logic [7:0] MOBUF_DI,
  output logic       MO_EMPTY,
  output logic       MO_FULL,
  output logic       MO_BUSY,
  output logic       MO_IRQ,
  output logic       MIDI_OUT
);

  localparam int BW = midi_cnt_width(BAUD_DIV);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(MIDI_DATA_BITS - 1);

  MidiTxState_t  state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shifter;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_ready;
  logic          bit_done;

  assign fifo_push  = MOBUF_WR && !RST;
  assign fifo_ready = (fifo_count != '0);
  assign bit_done   = CE && (baud_cnt == BAUD_LAST);

  // The head is taken when leaving IDLE or when a stop bit ends with more data queued.
  always_comb begin
    fifo_pop = 1'b0;
    if (!RST && CE && fifo_ready) begin
      case (state)
        IDLE:    fifo_pop = 1'b1;
        STOP:    fifo_pop = bit_done;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  scsp_midi_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (MOBUF_DI),
    .dout (fifo_head),
    .count(fifo_count),
    .empty(MO_EMPTY),
    .full (MO_FULL)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      MIDI_OUT <= 1'b1;
      MO_BUSY  <= 1'b0;
      MO_IRQ   <= 1'b0;
    end else begin
      MO_IRQ <= 1'b0;
      if (CE) begin
        case (state)
          IDLE: begin
            if (fifo_ready) begin
              state    <= START;
              shifter  <= fifo_head;
              baud_cnt <= '0;
              bit_cnt  <= '0;
              MIDI_OUT <= 1'b0;
              MO_BUSY  <= 1'b1;
            end
          end
          START: begin
            if (bit_done) begin
              state    <= DATA;
              baud_cnt <= '0;
              MIDI_OUT <= shifter[0];
              shifter  <= {1'b0, shifter[7:1]};
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_done) begin
              baud_cnt <= '0;
              if (bit_cnt == LAST_BIT) begin
                state    <= STOP;
                MIDI_OUT <= 1'b1;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                MIDI_OUT <= shifter[0];
                shifter  <= {1'b0, shifter[7:1]};
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_done) begin
              baud_cnt <= '0;
              // Chain straight into the next start bit so frames leave no idle gap.
              if (fifo_ready) begin
                state    <= START;
                shifter  <= fifo_head;
                bit_cnt  <= '0;
                MIDI_OUT <= 1'b0;
              end else begin
                state   <= IDLE;
                MO_BUSY <= 1'b0;
                MO_IRQ  <= 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            MIDI_OUT <= 1'b1;
            MO_BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scsp_midi_tx.sv
// Self-checking bench for scsp_midi_tx with BAUD_DIV=4, FIFO_DEPTH=4.
// A frame-level reference model predicts the line, flags and IRQ every clock.
module tb_scsp_midi_tx;

  localparam int B = 4;
  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       MOBUF_WR;
  logic [7:0] MOBUF_DI;
  logic       MO_EMPTY;
  logic       MO_FULL;
  logic       MO_BUSY;
  logic       MO_IRQ;
  logic       MIDI_OUT;

  scsp_midi_tx #(
    .BAUD_DIV  (B),
    .FIFO_DEPTH(D)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .MOBUF_WR(MOBUF_WR),
    .MOBUF_DI(MOBUF_DI),
    .MO_EMPTY(MO_EMPTY),
    .MO_FULL (MO_FULL),
    .MO_BUSY (MO_BUSY),
    .MO_IRQ  (MO_IRQ),
    .MIDI_OUT(MIDI_OUT)
  );

  always #5 CLK = ~CLK;

  wire [4:0] obs = {MIDI_OUT, MO_BUSY, MO_IRQ, MO_EMPTY, MO_FULL};

  int checks = 0;
  int errors = 0;
  int irq_seen;
  int busy_cycles;

  // Reference model: a byte queue and a position (in CE ticks) inside the current 10-bit frame.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_irq = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic void model_edge(input logic wr, input logic [7:0] di, input logic ce, input logic rst);
    m_irq = 1'b0;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos = 0;
    end else begin
      if (ce) begin
        if (m_active) begin
          m_pos++;
          if (m_pos == 10 * B) begin
            if (mq.size() > 0) begin
              m_cur = mq.pop_front();
              m_pos = 0;
            end else begin
              m_active = 1'b0;
              m_irq = 1'b1;
            end
          end
        end else if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_active = 1'b1;
          m_pos = 0;
        end
      end
      if (wr && mq.size() < D) mq.push_back(di);
    end
  endfunction

  function automatic logic [4:0] model_outs();
    logic line;
    line = m_active ? frame_bit(m_cur, m_pos / B) : 1'b1;
    return {line, m_active, m_irq, (mq.size() == 0), (mq.size() == D)};
  endfunction

  task automatic cycle(input logic wr, input logic [7:0] di, input logic ce, input logic rst);
    MOBUF_WR = wr;
    MOBUF_DI = di;
    CE = ce;
    RST = rst;
    @(posedge CLK);
    model_edge(wr, di, ce, rst);
    #1;
    if (MO_IRQ === 1'b1) irq_seen++;
    if (MO_BUSY === 1'b1) busy_cycles++;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hFF, 1'b1, 1'b1);
      checks++;
      if (obs !== 5'b10010) begin
        errors++;
        $display("[TB] FAIL reset_state: got %b expected %b", obs, 5'b10010);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    e = model_outs();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_single_frame();
    logic [4:0] e;
    logic line_s[50];
    int first;
    int run;
    irq_seen = 0;
    busy_cycles = 0;
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      line_s[i] = MIDI_OUT;
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL single_frame cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    first = -1;
    for (int i = 0; i < 50; i++) if (first < 0 && line_s[i] == 1'b0) first = i;
    run = 0;
    if (first >= 0) for (int i = first; i < 50 && line_s[i] == 1'b0; i++) run++;
    checks++;
    if (run != B) begin
      errors++;
      $display("[TB] FAIL single_start_len: got %0d expected %0d", run, B);
    end
    checks++;
    if (busy_cycles != 40) begin
      errors++;
      $display("[TB] FAIL single_frame_len: got %0d expected 40", busy_cycles);
    end
    checks++;
    if (irq_seen != 1) begin
      errors++;
      $display("[TB] FAIL single_irq_count: got %0d expected 1", irq_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    irq_seen = 0;
    busy_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL b2b_write %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (MO_FULL !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_full: got %b expected 1", MO_FULL);
    end
    for (int i = 0; i < 215; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL b2b cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (busy_cycles != 200) begin
      errors++;
      $display("[TB] FAIL b2b_busy_len: got %0d expected 200", busy_cycles);
    end
    checks++;
    if (irq_seen != 1) begin
      errors++;
      $display("[TB] FAIL b2b_irq_count: got %0d expected 1", irq_seen);
    end
  endtask

  task automatic test_full_drop();
    logic [4:0] e;
    irq_seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    e = model_outs();
    checks++;
    if (obs !== e || MO_FULL !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_full: got %b expected %b", obs, e);
    end
    for (int i = 0; i < 170; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL drop cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (busy_cycles != 160) begin
      errors++;
      $display("[TB] FAIL drop_frames: got %0d busy cycles expected 160", busy_cycles);
    end
  endtask

  task automatic test_push_pop_full();
    logic [4:0] e;
    irq_seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    checks++;
    if (MO_FULL !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pushpop_full: got %b expected 1", MO_FULL);
    end
    for (int i = 0; i < 210; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL pushpop cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (busy_cycles != 200 || irq_seen != 1) begin
      errors++;
      $display("[TB] FAIL pushpop_frames: got busy %0d irq %0d expected 200 1", busy_cycles, irq_seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] e;
    int n;
    cycle(1'b1, 8'hF0, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    n = 0;
    while (!(m_active && m_pos == 4 * B + 1) && n < 100) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL midrst_pre cyc %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL midrst_reach: got timeout expected bit 3 of frame");
    end
    irq_seen = 0;
    busy_cycles = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (MIDI_OUT !== 1'b1 || MO_EMPTY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_line: got out %b empty %b expected 1 1", MIDI_OUT, MO_EMPTY);
    end
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL midrst_post cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (irq_seen != 0 || busy_cycles != 0) begin
      errors++;
      $display("[TB] FAIL midrst_quiet: got irq %0d busy %0d expected 0 0", irq_seen, busy_cycles);
    end
  endtask

  task automatic test_ce_duty();
    logic [4:0] e;
    logic line_s[140];
    int first;
    int run;
    irq_seen = 0;
    busy_cycles = 0;
    cycle(1'b1, 8'h80, 1'b1, 1'b0);
    for (int k = 1; k < 140; k++) begin
      cycle(1'b0, 8'h00, (k % 3) == 0, 1'b0);
      line_s[k] = MIDI_OUT;
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL ce_duty cyc %0d: got %b expected %b", k, obs, e);
      end
    end
    first = -1;
    for (int k = 1; k < 140; k++) if (first < 0 && line_s[k] == 1'b0) first = k;
    run = 0;
    if (first >= 0) for (int k = first; k < 140 && line_s[k] == 1'b0; k++) run++;
    checks++;
    if (run != 96) begin
      errors++;
      $display("[TB] FAIL ce_duty_low_run: got %0d expected 96", run);
    end
    checks++;
    if (busy_cycles != 120 || irq_seen != 1) begin
      errors++;
      $display("[TB] FAIL ce_duty_frame: got busy %0d irq %0d expected 120 1", busy_cycles, irq_seen);
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 799) == 0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL random_drain cyc %0d: got %b expected %b", i, obs, e);
      end
    end
    checks++;
    if (obs !== 5'b10010) begin
      errors++;
      $display("[TB] FAIL random_idle: got %b expected %b", obs, 5'b10010);
    end
  endtask

  initial begin
    RST = 1'b1;
    CE = 1'b1;
    MOBUF_WR = 1'b0;
    MOBUF_DI = 8'h00;
    irq_seen = 0;
    busy_cycles = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_drop();
    test_push_pop_full();
    test_reset_mid_frame();
    test_ce_duty();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
